// File: rtl/shift_pkg.sv
// Shared types and helpers for the iterative shifter: FSM states, operation
// encodings and the saturated-result function used by the golden model.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Encodings of {in_left, in_arith}; in_arith has no effect on left shifts.
  localparam logic [1:0] OP_RIGHT_LOGIC = 2'b00;
  localparam logic [1:0] OP_RIGHT_ARITH = 2'b01;
  localparam logic [1:0] OP_LEFT        = 2'b10;
  localparam logic [1:0] OP_LEFT_ALT    = 2'b11;

  // Result of a shift whose amount is at least the operand width.
  function automatic logic [63:0] sat_result(input logic [63:0] data,
                                             input int          width,
                                             input logic        left,
                                             input logic        arith);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (!left && arith && data[width-1]) return mask;
    return '0;
  endfunction

endpackage

// File: rtl/shamt_clamp.sv
// Clamps a wide unsigned shift amount to the operand width. Every bit of the
// amount takes part in the compare, so very large amounts never wrap.
module shamt_clamp
  import shift_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int SHAMT_W = 36,
  localparam int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic [SHAMT_W-1:0] shamt,
  output logic [CNT_W-1:0]   eff,
  output logic               sat
);

  // One guard bit above the wider of the two widths keeps the high slice legal
  // even when the amount is narrower than the counter.
  localparam int EXT_W = ((SHAMT_W > CNT_W) ? SHAMT_W : CNT_W) + 1;
  localparam logic [CNT_W-1:0] MAX_EFF = CNT_W'(DATA_W);

  logic [EXT_W-1:0] shamt_ext;
  logic             high_set;

  always_comb begin
    shamt_ext = EXT_W'(shamt);
    high_set  = |shamt_ext[EXT_W-1:CNT_W];
    sat       = high_set || (shamt_ext[CNT_W-1:0] >= MAX_EFF);
    eff       = sat ? MAX_EFF : shamt_ext[CNT_W-1:0];
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: moves the operand one bit per clock until the clamped
// shift amount is used up, then holds the result until downstream takes it.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int SHAMT_W = 36,
  localparam int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  input  logic               in_left,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sat,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;
  logic               sign_q, sign_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [CNT_W-1:0]   eff;
  logic               sat;
  logic [DATA_W-1:0]  work_next;

  shamt_clamp #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_clamp (
    .shamt(in_shamt),
    .eff  (eff),
    .sat  (sat)
  );

  // Single-bit step; arithmetic fill uses the sign captured at accept time.
  always_comb begin
    case ({left_q, arith_q})
      OP_RIGHT_ARITH: work_next = {sign_q, work_q[DATA_W-1:1]};
      OP_LEFT,
      OP_LEFT_ALT:    work_next = {work_q[DATA_W-2:0], 1'b0};
      default:        work_next = {1'b0, work_q[DATA_W-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    left_d      = left_q;
    arith_d     = arith_q;
    sign_d      = sign_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d     = in_data;
          left_d     = in_left;
          arith_d    = in_arith;
          sign_d     = in_data[DATA_W-1];
          sat_d      = sat;
          cnt_d      = eff;
          in_ready_d = 1'b0;
          if (eff == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = work_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = work_next;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
      sign_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      left_q      <= left_d;
      arith_q     <= arith_d;
      sign_q      <= sign_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = sat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: an 8-bit instance driven through a
// scoreboard of model results, plus a 3-bit instance for the narrow-width case.
module tb_iter_shift_unit;
  import shift_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       sat;
    int         eff;
    int         t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  exp_t        sb[$];

  logic        a_in_valid, a_in_ready, a_in_arith, a_in_left;
  logic [7:0]  a_in_data, a_out_data;
  logic [35:0] a_in_shamt;
  logic        a_out_valid, a_out_ready, a_out_sat, a_busy;

  logic        b_in_valid, b_in_ready, b_in_arith, b_in_left;
  logic [2:0]  b_in_data, b_out_data;
  logic [35:0] b_in_shamt;
  logic        b_out_valid, b_out_ready, b_out_sat, b_busy;

  iter_shift_unit #(.DATA_W(8), .SHAMT_W(36)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_arith(a_in_arith), .in_left(a_in_left),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy)
  );

  iter_shift_unit #(.DATA_W(3), .SHAMT_W(36)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_arith(b_in_arith), .in_left(b_in_left),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // Free-running edge count used to measure latency from the accept edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result for the 8-bit instance, built from plain shift operators.
  function automatic exp_t modelShift(input logic [7:0] d, input logic [35:0] shamt,
                                      input logic arith, input logic left);
    exp_t e;
    logic signed [7:0] sd;
    sd    = d;
    e.sat = (shamt >= 36'd8);
    e.eff = e.sat ? 8 : int'(shamt);
    e.t0  = 0;
    if (e.sat)      e.data = 8'(sat_result(64'(d), 8, left, arith));
    else if (left)  e.data = 8'(d << e.eff);
    else if (arith) e.data = 8'(sd >>> e.eff);
    else            e.data = d >> e.eff;
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic [35:0] shamt,
                               input logic arith, input logic left);
    exp_t e;
    int   n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!a_in_ready) checkValue("in_ready_timeout", 64'(a_in_ready), 64'd1);
    e = modelShift(d, shamt, arith, left);
    a_in_data  = d;
    a_in_shamt = shamt;
    a_in_arith = arith;
    a_in_left  = left;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   n = 0;
    if (sb.size() == 0) begin
      checkValue({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    while (!a_out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkValue({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    checkValue({tag, "_latency"}, 64'(cyc - e.t0), 64'(e.eff));
    checkValue({tag, "_data"}, 64'(a_out_data), 64'(e.data));
    checkValue({tag, "_sat"}, 64'(a_out_sat), 64'(e.sat));
  endtask

  task automatic handshake(input string tag);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checkValue({tag, "_valid_drop"}, 64'(a_out_valid), 64'd0);
    checkValue({tag, "_ready_back"}, 64'(a_in_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] held_data;
    logic       held_sat;
    int         t0b;
    int         n;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_arith = 1'b0; a_in_left = 1'b0;
    a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_arith = 1'b0; b_in_left = 1'b0;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst_in_ready", 64'(a_in_ready), 64'd1);
    checkValue("rst_out_valid", 64'(a_out_valid), 64'd0);
    checkValue("rst_out_data", 64'(a_out_data), 64'd0);
    checkValue("rst_out_sat", 64'(a_out_sat), 64'd0);
    checkValue("rst_busy", 64'(a_busy), 64'd0);
    checkValue("rst_b_out_data", 64'(b_out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'h90, 36'd2, 1'b1, 1'b0);
    checkOutput("arith_r2");
    handshake("arith_r2");
    applyStimulus(8'h90, 36'd2, 1'b0, 1'b0);
    checkOutput("logic_r2");
    handshake("logic_r2");
    applyStimulus(8'h81, 36'd1, 1'b0, 1'b1);
    checkOutput("left_1");
    handshake("left_1");
    applyStimulus(8'h80, 36'h1_0000_0000, 1'b1, 1'b0);
    checkOutput("sat_wide");
    handshake("sat_wide");
    applyStimulus(8'h6C, 36'd8, 1'b0, 1'b1);
    checkOutput("sat_left8");
    handshake("sat_left8");
    applyStimulus(8'hA5, 36'd0, 1'b1, 1'b0);
    checkOutput("shamt0");
    handshake("shamt0");

    // Backpressure: result must hold while a competing request is offered.
    a_out_ready = 1'b0;
    applyStimulus(8'hC3, 36'd3, 1'b1, 1'b0);
    checkOutput("bp");
    held_data = a_out_data;
    held_sat  = a_out_sat;
    a_in_data = 8'h11; a_in_shamt = 36'd0; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkValue("bp_hold_data", 64'(a_out_data), 64'(held_data));
      checkValue("bp_hold_sat", 64'(a_out_sat), 64'(held_sat));
      checkValue("bp_in_ready", 64'(a_in_ready), 64'd0);
    end
    handshake("bp");
    a_in_valid = 1'b0;
    checkValue("bp_no_accept", 64'(a_busy), 64'd0);
    @(posedge clk); #1;
    checkValue("bp_still_idle", 64'(a_busy), 64'd0);

    // Asynchronous reset three edges into a seven-step shift.
    applyStimulus(8'h55, 36'd7, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checkValue("midrst_in_ready", 64'(a_in_ready), 64'd1);
    checkValue("midrst_out_valid", 64'(a_out_valid), 64'd0);
    checkValue("midrst_out_data", 64'(a_out_data), 64'd0);
    checkValue("midrst_out_sat", 64'(a_out_sat), 64'd0);
    checkValue("midrst_busy", 64'(a_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(8'h3C, 36'd5, 1'b0, 1'b0);
    checkOutput("post_rst");
    handshake("post_rst");

    // Narrow instance: an all-ones 36-bit amount saturates to three steps.
    b_in_data = 3'b011; b_in_shamt = 36'hf_ffff_ffff; b_in_arith = 1'b1; b_in_left = 1'b0;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    t0b = cyc;
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkValue("w3_valid", 64'(b_out_valid), 64'd1);
    checkValue("w3_latency", 64'(cyc - t0b), 64'd3);
    checkValue("w3_data", 64'(b_out_data), sat_result(64'(3'b011), 3, 1'b0, 1'b1));
    checkValue("w3_sat", 64'(b_out_sat), 64'd1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
